// File: rtl/gate_function_identifier.sv
// gate_function_identifier
//   Characterisation engine for an external two-input, one-output gate. It
//   drives every input vector {a,b} = 00, 01, 10, 11 onto the gate under test,
//   lets each vector settle and samples the response into a 4-entry truth
//   table. It then decodes that table to a gate type.
//
// Build option: GATE_ID_MAJORITY_EN
//   When this macro is defined, each vector is sampled on three consecutive
//   cycles and the 2-of-3 majority is stored. This rejects single-cycle
//   glitches on gate_in.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   start     sweep request, accepted only while busy=0
//   gate_in   response from the gate under test
//   a_drv     stimulus a to the gate under test
//   b_drv     stimulus b to the gate under test
//   busy      high from start acceptance until done
//   done      one-cycle pulse; tt/gate_id/valid_id are valid from this cycle
//   tt        truth table, tt[{a,b}] = sampled gate_in
//   gate_id   0 UNKNOWN, 1 NOT(a), 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR
//   valid_id  1 when tt matches a known gate
//
// state  | meaning
// IDLE   | waiting for start, stimulus parked at 00
// DRIVE  | vector k applied, settle down-counter running
// SAMPLE | vector k still applied, gate_in captured into shadow[k]
// DECODE | shadow copied to result registers, done pulsed
module gate_function_identifier #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_in,
  output logic       a_drv,
  output logic       b_drv,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic [2:0] gate_id,
  output logic       valid_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DECODE = 2'd3
  } state_t;

  // The down-counter starts at SETTLE_CYCLES-1 and reaches 0 in the last
  // settle cycle, so DRIVE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] k;
  logic [3:0] settle_cnt;
  logic [3:0] shadow;
  logic       sample_last;
  logic       sample_bit;
  logic [2:0] dec_id;

`ifdef GATE_ID_MAJORITY_EN
  logic [1:0] samp_cnt;
  logic [1:0] samp_hist;

  assign sample_last = (samp_cnt == 2'd2);
  assign sample_bit  = (samp_hist[0] & samp_hist[1]) |
                       (samp_hist[0] & gate_in) |
                       (samp_hist[1] & gate_in);
`else
  assign sample_last = 1'b1;
  assign sample_bit  = gate_in;
`endif

  // The stimulus is combinational from the state. This keeps a/b aligned with
  // the state, so a reset parks them at 00 in the very next cycle.
  always_comb begin
    a_drv = 1'b0;
    b_drv = 1'b0;
    if (state == DRIVE || state == SAMPLE) begin
      a_drv = k[1];
      b_drv = k[0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = DRIVE;
      DRIVE:  if (settle_cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE: if (sample_last) state_nxt = (k == 2'd3) ? DECODE : DRIVE;
      DECODE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dec_id = 3'd0;
    case (shadow)
      4'b0011: dec_id = 3'd1;
      4'b1000: dec_id = 3'd2;
      4'b1110: dec_id = 3'd3;
      4'b0111: dec_id = 3'd4;
      4'b0001: dec_id = 3'd5;
      4'b0110: dec_id = 3'd6;
      4'b1001: dec_id = 3'd7;
      default: dec_id = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      settle_cnt <= 4'd0;
      shadow     <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= 4'd0;
      gate_id    <= 3'd0;
      valid_id   <= 1'b0;
`ifdef GATE_ID_MAJORITY_EN
      samp_cnt   <= 2'd0;
      samp_hist  <= 2'd0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow     <= 4'd0;
            k          <= 2'd0;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
`ifdef GATE_ID_MAJORITY_EN
            samp_cnt   <= 2'd0;
`endif
          end
        end
        DRIVE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
`ifdef GATE_ID_MAJORITY_EN
          if (samp_cnt == 2'd0) samp_hist[0] <= gate_in;
          if (samp_cnt == 2'd1) samp_hist[1] <= gate_in;
          samp_cnt <= sample_last ? 2'd0 : samp_cnt + 2'd1;
`endif
          if (sample_last) begin
            shadow[k] <= sample_bit;
            // k stops at 3; the sweep leaves through DECODE instead of wrapping.
            if (k != 2'd3) begin
              k          <= k + 2'd1;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        DECODE: begin
          tt       <= shadow;
          gate_id  <= dec_id;
          valid_id <= (dec_id != 3'd0);
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_function_identifier.sv
// Self-checking bench for gate_function_identifier.
// A behavioural gate model answers from a 4-entry table indexed by {a,b}.
// Expected results are derived by evaluating the seven gate functions
// arithmetically.
module tb_gate_function_identifier;

  localparam int S = 2;
`ifdef GATE_ID_MAJORITY_EN
  localparam int SAMP = 3;
`else
  localparam int SAMP = 1;
`endif
  localparam int LAT = 4 * (S + SAMP) + 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       gate_in;
  logic       a_drv;
  logic       b_drv;
  logic       busy;
  logic       done;
  logic [3:0] tt;
  logic [2:0] gate_id;
  logic       valid_id;

  logic [3:0] model_tt;
  logic       glitch;

  int n_tests;
  int n_fail;

  logic [3:0] exp_tt;
  logic [2:0] exp_id;
  logic       exp_valid;

  gate_function_identifier #(.SETTLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .gate_in  (gate_in),
    .a_drv    (a_drv),
    .b_drv    (b_drv),
    .busy     (busy),
    .done     (done),
    .tt       (tt),
    .gate_id  (gate_id),
    .valid_id (valid_id)
  );

  assign gate_in = model_tt[{a_drv, b_drv}] ^ glitch;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Searches the seven known gate functions for one whose table equals t.
  function automatic logic [2:0] ref_id(input logic [3:0] t);
    logic [3:0] tbl;
    logic       a;
    logic       b;
    logic       o;
    for (int g = 1; g <= 7; g++) begin
      tbl = 4'd0;
      for (int v = 0; v < 4; v++) begin
        a = v[1];
        b = v[0];
        case (g)
          1: o = !a;
          2: o = a && b;
          3: o = a || b;
          4: o = !(a && b);
          5: o = !(a || b);
          6: o = a != b;
          default: o = a == b;
        endcase
        tbl[v] = o;
      end
      if (tbl == t) return 3'(g);
    end
    return 3'd0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_a"}, 32'(a_drv), 32'd0);
    check({tag, "_b"}, 32'(b_drv), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tt"}, 32'(tt), 32'd0);
    check({tag, "_id"}, 32'(gate_id), 32'd0);
    check({tag, "_valid"}, 32'(valid_id), 32'd0);
  endtask

  // Runs one sweep with table t. When called at the #1 point of a done cycle,
  // the sweep starts in that done cycle.
  task automatic sweep(input logic [3:0] t, input bit poke_start, input bit do_glitch);
    int         cyc;
    bit         stable;
    logic [1:0] seq[$];
    logic [1:0] ab;
    logic [7:0] packed_seq;
    model_tt = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    stable = 1'b1;
    seq = {};
    check("done_low_after_accept", 32'(done), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && cyc < LAT + 20) begin
      ab = {a_drv, b_drv};
      if (cyc < 4 * (S + SAMP) && (seq.size() == 0 || seq[$] != ab)) seq.push_back(ab);
      if (tt !== exp_tt || gate_id !== exp_id || valid_id !== exp_valid) stable = 1'b0;
      if (poke_start) start = (cyc == 3);
      if (do_glitch) glitch = (cyc == 3 * (S + SAMP) + S + 1);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    glitch = 1'b0;
    exp_tt = t;
    exp_id = ref_id(t);
    exp_valid = (exp_id != 3'd0);
    packed_seq = 8'd0;
    for (int i = 0; i < 4 && i < seq.size(); i++) packed_seq = {packed_seq[5:0], seq[i]};
    check("latency", 32'(cyc), 32'(LAT));
    check("result_held_during_sweep", 32'(stable), 32'd1);
    check("vector_count", 32'(seq.size()), 32'd4);
    check("vector_order", 32'(packed_seq), 32'h1B);
    check("tt", 32'(tt), 32'(exp_tt));
    check("gate_id", 32'(gate_id), 32'(exp_id));
    check("valid_id", 32'(valid_id), 32'(exp_valid));
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    glitch = 1'b0;
    model_tt = 4'd0;
    exp_tt = 4'd0;
    exp_id = 3'd0;
    exp_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy_start_low", 32'(busy), 32'd0);

    sweep(4'b1000, 1'b0, 1'b0);
    sweep(4'b0110, 1'b0, 1'b0);
    sweep(4'b0011, 1'b0, 1'b0);
    sweep(4'b1111, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("hold_tt", 32'(tt), 32'(exp_tt));
    check("hold_id", 32'(gate_id), 32'(exp_id));
    check("hold_valid", 32'(valid_id), 32'(exp_valid));

    model_tt = 4'b1000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("abort");
    exp_tt = 4'd0;
    exp_id = 3'd0;
    exp_valid = 1'b0;
    rst = 1'b0;

    sweep(4'b1110, 1'b1, 1'b0);

    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("rst_beats_start_busy", 32'(busy), 32'd0);
    check("rst_beats_start_tt", 32'(tt), 32'd0);
    exp_tt = 4'd0;
    exp_id = 3'd0;
    exp_valid = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst_start", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) sweep(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    sweep(4'b1001, 1'b0, 1'b0);
    sweep(4'b0001, 1'b0, 1'b0);

`ifdef GATE_ID_MAJORITY_EN
    sweep(4'b1110, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
